riscv_mem_responder: RTL

//  Memory-side responder for riscv_core's instruction-fetch and data ports: serves inst for inst_addr and
//  mem_data_out[0:3] for mem_addr; commits mem_data_in[0:3] when mem_write_en is high.

---
 rtl/riscv_mem_pkg.sv | 30 +++
 rtl/mem_rd_pipe.sv | 37 +++
 rtl/riscv_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and address helpers for the riscv_core memory responder.
// Lane 0 is the least-significant byte of a word (little-endian).
package riscv_mem_pkg;

   localparam int LANES = 4;

   typedef logic [7:0]  byte_t;
   typedef byte_t       lanes_t [0:LANES-1];
   typedef logic [31:0] word_t;

   function automatic logic is_misaligned(input word_t addr);
      return addr[1:0] != 2'b00;
   endfunction

   // Everything above the word index and byte offset must be zero.
   function automatic logic in_range(input word_t addr, input int aw);
      return (addr >> (aw + 2)) == '0;
   endfunction

   function automatic word_t pack_lanes(input lanes_t l);
      return {l[3], l[2], l[1], l[0]};
   endfunction

   function automatic void unpack_lanes(input word_t w, output lanes_t l);
      for (int i = 0; i < LANES; i++) begin
         l[i] = w[8*i +: 8];
      end
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency delay line carrying {valid, data}; RD_LATENCY cycles, no backpressure.
// Reset clears every stage so in-flight reads are discarded immediately.
module mem_rd_pipe #(
   parameter int RD_LATENCY = 1,
   parameter int W          = 32
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [RD_LATENCY-1:0] vld_q;
   logic [W-1:0]          dat_q [RD_LATENCY];

   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         dat_q[0] <= in_data;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[RD_LATENCY-1];
   assign out_data  = dat_q[RD_LATENCY-1];

endmodule

// File: rtl/riscv_mem_responder.sv
// Word-organised memory serving riscv_core fetch and data ports; reads return after RD_LATENCY cycles.
// No backpressure: both ports accept one access per cycle, writes are write-first, errors are sticky.
module riscv_mem_responder
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic [31:0] mem_addr,
   input  logic [7:0]  mem_data_in [0:3],
   input  logic        mem_write_en,
   output logic [7:0]  mem_data_out [0:3],
   output logic        mem_data_valid,
   input  logic        halted,
   output logic        misalign_err,
   output logic        range_err
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   word_t                 mem [DEPTH];

   logic [ADDR_WIDTH-1:0] inst_idx;
   logic [ADDR_WIDTH-1:0] data_idx;
   logic                  inst_mis;
   logic                  inst_rng;
   logic                  data_mis;
   logic                  data_rng;
   logic                  wr_fire;
   word_t                 wr_word;
   word_t                 inst_rd;
   word_t                 data_rd;
   word_t                 data_word;
   logic                  fetch_vld;

   assign inst_idx = inst_addr[ADDR_WIDTH+1:2];
   assign data_idx = mem_addr[ADDR_WIDTH+1:2];
   assign inst_mis = is_misaligned(inst_addr);
   assign inst_rng = in_range(inst_addr, ADDR_WIDTH);
   assign data_mis = is_misaligned(mem_addr);
   assign data_rng = in_range(mem_addr, ADDR_WIDTH);
   assign wr_word  = pack_lanes(mem_data_in);
   assign wr_fire  = !rst_b && mem_write_en && !halted && !data_mis && data_rng;

   // Out-of-range reads return zero; a same-cycle write to the word wins over the array.
   always_comb begin
      inst_rd = '0;
      if (inst_rng) begin
         inst_rd = (wr_fire && (data_idx == inst_idx)) ? wr_word : mem[inst_idx];
      end
   end

   always_comb begin
      data_rd = '0;
      if (data_rng) begin
         data_rd = wr_fire ? wr_word : mem[data_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[data_idx] <= wr_word;
      end
   end

   // The data port reads every cycle, so it only raises errors for writes.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         misalign_err <= 1'b0;
         range_err    <= 1'b0;
      end else begin
         if (inst_mis || (mem_write_en && data_mis)) begin
            misalign_err <= 1'b1;
         end
         if (!inst_rng || (mem_write_en && !data_rng)) begin
            range_err <= 1'b1;
         end
      end
   end

   assign fetch_vld = !halted;

   mem_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .W          (32)
   ) u_inst_pipe (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (fetch_vld),
      .in_data   (inst_rd),
      .out_valid (inst_valid),
      .out_data  (inst)
   );

   mem_rd_pipe #(
      .RD_LATENCY (RD_LATENCY),
      .W          (32)
   ) u_data_pipe (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (1'b1),
      .in_data   (data_rd),
      .out_valid (mem_data_valid),
      .out_data  (data_word)
   );

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign mem_data_out[i] = data_word[8*i +: 8];
   end

endmodule
